fp_result_wb: RTL and testbench

Writeback/retire stage directly downstream of the FP conversion unit. It captures each result with its exception flags into a small in-order FIFO. It normalises the 64-bit result for register-file write: NaN-boxing for FP32, sign- or zero-extension for 32-bit integers. It accumulates retired flags into a sticky fflags register with software clear/write and drains results to the register-file write port over a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fpu_fifo.sv | 56 +++++
 rtl/fp_result_wb.sv | 99 +++++++++
 tb/tb_fp_result_wb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP-unit types: result type encoding, exception flag layout and the
// register-file normalisation helper used at writeback.
package fpu_pkg;

  typedef enum logic [1:0] {
    FP32   = 2'b00,
    FP64   = 2'b01,
    INT32  = 2'b10,
    UINT32 = 2'b11
  } fp_type_e;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;

  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  // Widen a raw converter result into its 64-bit register-file image.
  function automatic logic [63:0] normalise(input fp_type_e t, input logic [63:0] r);
    logic [63:0] v;
    case (t)
      FP32:    v = {NANBOX_HI, r[31:0]};
      INT32:   v = {{32{r[31]}}, r[31:0]};
      UINT32:  v = {32'h0000_0000, r[31:0]};
      default: v = r;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fpu_fifo.sv
// Generic synchronous FIFO with flush; rdata reads 0 while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked until an entry is written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp_result_wb.sv
// FP result writeback: normalise, queue in order, retire to the register file
// and accumulate sticky fflags. Optional trap output under FPWB_TRAP_EN.
module fp_result_wb
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_result,
  input  logic [3:0]                 in_flags,
  input  logic [1:0]                 in_out_type,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_result,
  output logic [3:0]                 out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [3:0]                 fflags,
  input  logic                       fflags_clr,
  input  logic                       fflags_wr,
  input  logic [3:0]                 fflags_wdata
`ifdef FPWB_TRAP_EN
  ,
  input  logic [3:0]                 trap_mask,
  output logic                       trap
`endif
);

  localparam int EW = TAG_W + 4 + 64;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high and flush is low; valid never waits on ready, and in_ready
  // depends only on registered occupancy.
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  fp_flags_t     head_flags;
  fp_flags_t     fflags_q;
  fp_flags_t     fflags_base;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign wdata = {in_tag, in_flags, normalise(fp_type_e'(in_out_type), in_result)};

  fpu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign out_result = rdata[63:0];
  assign out_flags  = rdata[67:64];
  assign out_tag    = rdata[EW-1:68];
  assign head_flags = fp_flags_t'(out_flags);

  // Software write beats clear; retiring flags are OR-ed in regardless.
  always_comb begin
    fflags_base = fflags_q;
    if (fflags_wr)       fflags_base = fp_flags_t'(fflags_wdata);
    else if (fflags_clr) fflags_base = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_base | (pop ? head_flags : fp_flags_t'(4'b0000));
  end

  assign fflags = fflags_q;

`ifdef FPWB_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst || flush) trap <= 1'b0;
    else              trap <= pop && ((out_flags & trap_mask) != 4'b0000);
  end
`endif

endmodule

// File: tb/tb_fp_result_wb.sv
// Directed scoreboard bench for fp_result_wb (default build; trap checks run
// only when FPWB_TRAP_EN is defined).
module tb_fp_result_wb;

  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam int EW    = TAG_W + 4 + 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_result;
  logic [3:0]       in_flags;
  logic [1:0]       in_out_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [2:0]       count;
  logic [3:0]       fflags;
  logic             fflags_clr;
  logic             fflags_wr;
  logic [3:0]       fflags_wdata;
`ifdef FPWB_TRAP_EN
  logic [3:0]       trap_mask;
  logic             trap;
`endif

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  fp_result_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_out_type  (in_out_type),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .count        (count),
    .fflags       (fflags),
    .fflags_clr   (fflags_clr),
    .fflags_wr    (fflags_wr),
    .fflags_wdata (fflags_wdata)
`ifdef FPWB_TRAP_EN
    ,
    .trap_mask    (trap_mask),
    .trap         (trap)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a transfer completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_retire: got tag %0d result %h, expected nothing", out_tag, out_result);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_tag, out_flags, out_result} !== e) begin
          fails++;
          $display("FAIL retire: got tag %0d flags %b result %h, expected tag %0d flags %b result %h",
                   out_tag, out_flags, out_result, e[EW-1:68], e[67:64], e[63:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic push_one(input logic [1:0] ty, input logic [63:0] res, input logic [3:0] fl,
                          input logic [TAG_W-1:0] tg, input logic [63:0] exp_res, input bit keep);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("push_wait_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid    = 1'b1;
    in_out_type = ty;
    in_result   = res;
    in_flags    = fl;
    in_tag      = tg;
    if (keep) exp_q.push_back({tg, fl, exp_res});
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (count != 0 && n < 50) begin
      step();
      n++;
    end
    check("drain_count_zero", {61'd0, count}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
    in_out_type = 2'b00; in_tag = '0; out_ready = 1'b0;
    fflags_clr = 1'b0; fflags_wr = 1'b0; fflags_wdata = '0;
`ifdef FPWB_TRAP_EN
    trap_mask = 4'b0000;
`endif
    step(); step();
    rst = 1'b0;
    check("reset_count", {61'd0, count}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_fflags", {60'd0, fflags}, 64'd0);
    check("reset_out_result", out_result, 64'd0);
    check("reset_out_tag_flags", {55'd0, out_tag, out_flags}, 64'd0);

    // normalisation
    out_ready = 1'b1;
    push_one(2'b00, 64'h0000_0000_3F80_0000, 4'b0000, 5'd1, 64'hFFFF_FFFF_3F80_0000, 1);
    check("latency_out_valid", {63'd0, out_valid}, 64'd1);
    push_one(2'b10, 64'h1234_5678_8000_0000, 4'b0000, 5'd2, 64'hFFFF_FFFF_8000_0000, 1);
    push_one(2'b11, 64'h1234_5678_8000_0000, 4'b0000, 5'd3, 64'h0000_0000_8000_0000, 1);
    push_one(2'b10, 64'hFFFF_0000_7FFF_FFFF, 4'b0000, 5'd4, 64'h0000_0000_7FFF_FFFF, 1);
    push_one(2'b01, 64'hDEAD_BEEF_0123_4567, 4'b0000, 5'd5, 64'hDEAD_BEEF_0123_4567, 1);
    drain();

    // full FIFO, simultaneous push+pop refused
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      push_one(2'b01, 64'(i) * 64'h1111, 4'b0000, 5'(i), 64'(i) * 64'h1111, 1);
    check("full_count", {61'd0, count}, 64'd4);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b1; in_tag = 5'd9; in_out_type = 2'b01; in_result = 64'h9999;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_push_pop_count", {61'd0, count}, 64'd3);
    step();
    check("hold_stable_tag", {59'd0, out_tag}, 64'd2);
    drain();

    // sticky flags
    fflags_clr = 1'b1; step(); fflags_clr = 1'b0;
    push_one(2'b01, 64'h1, 4'b0001, 5'd10, 64'h1, 1);
    push_one(2'b01, 64'h2, 4'b1000, 5'd11, 64'h2, 1);
    drain();
    check("fflags_accum", {60'd0, fflags}, 64'h9);
    out_ready = 1'b0;
    push_one(2'b01, 64'h3, 4'b0100, 5'd12, 64'h3, 1);
    check("fflags_not_at_push", {60'd0, fflags}, 64'h9);
    fflags_clr = 1'b1; out_ready = 1'b1;
    step();
    fflags_clr = 1'b0; out_ready = 1'b0;
    check("fflags_clr_with_pop", {60'd0, fflags}, 64'h4);
    push_one(2'b01, 64'h4, 4'b0001, 5'd13, 64'h4, 1);
    fflags_wr = 1'b1; fflags_wdata = 4'b0010; fflags_clr = 1'b1; out_ready = 1'b1;
    step();
    fflags_wr = 1'b0; fflags_clr = 1'b0; out_ready = 1'b0;
    check("fflags_wr_with_pop", {60'd0, fflags}, 64'h3);

    // flush
    for (int i = 0; i < 3; i++)
      push_one(2'b01, 64'h77, 4'b1111, 5'(20 + i), 64'h77, 0);
    check("pre_flush_count", {61'd0, count}, 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd30; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush_count", {61'd0, count}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_fflags", {60'd0, fflags}, 64'h3);
    step();
    check("flush_push_discarded", {61'd0, count}, 64'd0);

    // reset mid-operation
    fflags_wr = 1'b1; fflags_wdata = 4'b0110; step(); fflags_wr = 1'b0;
    push_one(2'b01, 64'h55, 4'b0000, 5'd1, 64'h55, 0);
    push_one(2'b01, 64'h66, 4'b0000, 5'd2, 64'h66, 0);
    check("pre_rst_fflags", {60'd0, fflags}, 64'h6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_fflags", {60'd0, fflags}, 64'd0);

`ifdef FPWB_TRAP_EN
    trap_mask = 4'b1000;
    push_one(2'b01, 64'hA, 4'b0001, 5'd3, 64'hA, 1);
    push_one(2'b01, 64'hB, 4'b1001, 5'd4, 64'hB, 1);
    out_ready = 1'b1;
    step();
    check("trap_masked_off", {63'd0, trap}, 64'd0);
    step();
    check("trap_pulse", {63'd0, trap}, 64'd1);
    step();
    check("trap_one_cycle", {63'd0, trap}, 64'd0);
    out_ready = 1'b0;
`endif

    step(); step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
